// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - operation request and result bundle for serial_add_sub
//
// Ports (seen from the slave / datapath side):
//   start    in   begin an operation (sampled when the block is ready)
//   sub      in   0 = a+b, 1 = a-b
//   a, b     in   WIDTH-bit operands, sampled with start
//   busy     out  bits are being processed
//   done     out  one-cycle pulse, published outputs valid from here on
//   result   out  WIDTH-bit sum/difference
//   cout     out  carry out of the MSB (for subtract, 1 = no borrow)
//   overflow out  signed overflow
//   zero     out  result == 0
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor built around one full adder
//
// full_adder ports:
//   a, b, cin  in   addend bits and carry in
//   sum, cout  out  sum bit and carry out
//
// serial_add_sub ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset
//   bus  slave side of serial_add_sub_if (request in, busy/done/result out)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_sub_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               last;

    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_sum;
    logic               fa_cout;

    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               overflow_q;
    logic               zero_q;

    full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
    assign res_next = {fa_sum, res_sh[WIDTH-1:1]};
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a       <= '0;
            sh_b       <= '0;
            res_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b here, the +1 is the initial carry.
            sh_a   <= bus.a;
            sh_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            cnt    <= '0;
            res_sh <= '0;
        end else if (step) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            res_sh <= res_next;
            carry  <= fa_cout;
            cnt    <= last ? '0 : cnt + CNT_W'(1);
            if (last) begin
                // carry currently holds the carry into the MSB.
                result_q   <= res_next;
                cout_q     <= fa_cout;
                overflow_q <= carry ^ fa_cout;
                zero_q     <= (res_next == '0);
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder/subtractor that computes WIDTH-bit A+B or A−B one bit per clock through a single `full_adder` instance. A carry flip-flop sits around the adder, and operand/result shift registers and a small FSM sequence the bits. It sits directly downstream of `full_adder` as its only consumer in the arithmetic path. It is the low-area ALU option for the SAP-1 datapath, trading latency for a single adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when the block is ready.
- sub  input  1  0 = A+B, 1 = A−B (two's complement); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse; result/flags valid from this cycle on.
- result  output  WIDTH  registered sum/difference.
- cout  output  1  final carry out of MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

## Operation
- Exactly one `full_adder` instance, with ports a, b, cin, sum, cout. Its inputs are shift-A bit 0, shift-B bit 0, and the carry flip-flop.
- States: IDLE, SHIFT, DONE.
- **IDLE:** busy=0, done=0.
  - On start=1: load shift-A←a and shift-B←(sub ? ~b : b).
  - Set carry←sub, bit counter←0, and go to SHIFT.
- **SHIFT:** busy=1. Each cycle:
  - Shift the adder sum into the MSB of the internal result shift register.
  - Shift shift-A and shift-B right by one.
  - Set carry←adder cout and increment the counter.
- **Last bit (counter = WIDTH−1):**
  - result←final shifted value, including this bit.
  - cout←adder cout.
  - overflow←carry flip-flop (carry into MSB) XOR adder cout.
  - zero←(final value == 0).
  - Go to DONE.
- **DONE:** done=1, busy=0.
  - On start=1, accept a new operation exactly as in IDLE and go to SHIFT.
  - Otherwise go to IDLE.
- The published result/cout/overflow/zero registers update only on the last-bit edge. They hold between operations and are not cleared by a new start.
- start while in SHIFT is ignored. Changes on a, b or sub during SHIFT have no effect.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1 via carry-in = 1.

## Timing
- Reset: asynchronous. state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, zero=0, internal registers cleared.
- Reset asserted mid-operation aborts the operation; no done pulse is produced after release.
- With start sampled high at edge n in IDLE/DONE:
  - busy is high from edge n to edge n+WIDTH.
  - done is high from edge n+WIDTH to edge n+WIDTH+1.
  - Latency is WIDTH cycles, start to done.
- Back-to-back: start held high during the done cycle is accepted at edge n+WIDTH+1. The next done is at n+2·WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- busy and done are never high together. done is never high for two consecutive cycles.
- Counter width is $clog2(WIDTH); the counter never wraps within an operation.

## Test plan
- **Reset:**
  - Stimulus: assert rst asynchronously mid-cycle.
  - Response: busy=0, done=0, result=8'h00, cout=0, overflow=0, zero=0 immediately, with no clock edge needed.
- **Add:**
  - Stimulus: WIDTH=8, start with a=8'h3C, b=8'h05, sub=0.
  - Response: busy for 8 cycles, then a one-cycle done with result=8'h41, cout=0, overflow=0, zero=0.
- **Carry/zero, then signed overflow on add:**
  - Stimulus: a=8'hFF, b=8'h01, sub=0.
  - Response: result=8'h00, cout=1, zero=1, overflow=0.
  - Stimulus: a=8'h7F, b=8'h01.
  - Response: result=8'h80, overflow=1, cout=0.
- **Subtract:**
  - 8'h05−8'h05 gives result=8'h00, cout=1, zero=1.
  - 8'h03−8'h05 gives result=8'hFE, cout=0.
  - 8'h80−8'h01 gives result=8'h7F, cout=1, overflow=1.
- **Ignored inputs and back-to-back:**
  - Stimulus: during busy, pulse start and change a/b/sub.
  - Response: the original operation's result is unchanged, and there is exactly one done.
  - Stimulus: hold start high through the done cycle.
  - Response: the second operation's done arrives WIDTH+1 cycles after the first.
- **Reset mid-operation:**
  - Stimulus: assert rst after 4 of 8 bits, then release.
  - Response: all outputs are 0, there is no done, and a new start completes normally in 8 cycles.
